uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter (tx_start / data_in / tx_done) between NUM_REQ byte requesters.

---
 rtl/uart_ctrl_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 51 +++++
 rtl/uart_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Purpose: shared types and helpers for the UART TX scheduler slice.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   sched_state_e : scheduler FSM states IDLE -> START -> WAIT -> IDLE
//   DATA_W_DEF    : default byte width, matches the UART data_in width
//   grant_idx_w() : width of a requester index (never below 1 bit)
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int DATA_W_DEF = 8;

  function automatic int grant_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Purpose: round-robin pick of the first set request at or above a pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
//
// Ports:
//   i_req     in  NUM_REQ  request vector
//   i_ptr     in  IDX_W    search start index (always < NUM_REQ)
//   o_gnt_oh  out NUM_REQ  one-hot winner (all zero when nothing requests)
//   o_gnt_idx out IDX_W    binary index of the winner
//   o_any     out 1        at least one request is set
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = grant_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_sum;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_sum     = '0;
    w_pos     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(k);
      // i_ptr < NUM_REQ and k < NUM_REQ, so one subtraction is a full modulo.
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_pos = w_sum[IDX_W-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_gnt_oh[w_pos] = 1'b1;
        o_gnt_idx       = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose: share one UART transmitter between NUM_REQ byte requesters, round-robin, one byte per grant.
// Latency: req_valid in IDLE at cycle t -> req_ack at t+1, tx_start at t+2; tx_done at t -> next tx_start at t+3.
// Backpressure: a requester holds req_valid until its req_ack pulse; no new grant until the UART reports tx_done.
//
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (abort after TIMEOUT_CYC cycles without tx_done, pulse timeout_err). Undefined:
// WAIT holds until tx_done and timeout_err is tied low.
//
// Ports:
//   clk          in   1               system clock
//   rst          in   1               asynchronous active-low reset
//   req_valid    in   NUM_REQ         requester i has a byte pending
//   req_data     in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//   req_ack      out  NUM_REQ         one-hot 1-cycle pulse, byte of requester i taken
//   tx_start     out  1               1-cycle start pulse to the UART
//   data_in      out  DATA_W          byte to the UART, stable for the whole transfer
//   tx_done      in   1               UART finished the current byte
//   busy         out  1               a transfer is in START or WAIT
//   grant_id     out  IDX_W           requester currently being served
//   timeout_err  out  1               1-cycle pulse on watchdog abort
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_W      = DATA_W_DEF,
  parameter int  TIMEOUT_CYC = 20000,
  localparam int IDX_W       = grant_idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         data_in,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      timeout_err
);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant_id;
  logic [DATA_W-1:0]  r_data;
  logic [NUM_REQ-1:0] r_req_ack;
  logic               r_tx_start;
  logic               r_timeout_err;

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any;

  logic               w_grant;    // arbitration result taken this cycle
  logic               w_finish;   // transfer ends this cycle (done or abort)
  logic               w_expire;   // watchdog limit reached in WAIT
  logic               w_timeout;  // expiry without a coincident tx_done

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_oh  (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = grant_idx_w(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_wait_cnt;

  // Held at zero outside WAIT, so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_expire = (r_state == WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  // Keeps the limit referenced while the watchdog is compiled out.
  logic [31:0] w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = TIMEOUT_CYC;
  assign w_expire             = 1'b0;
`endif

  // A tx_done arriving on the expiry cycle is a normal finish, not an error.
  assign w_timeout = w_expire && !tx_done;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state. tx_done is only looked at in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done || w_expire) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and output pulses. tx_start is registered from START so it lands
  // on the first WAIT cycle, two cycles after the request was seen in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_data        <= '0;
      r_req_ack     <= '0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ack     <= '0;
      r_tx_start    <= (r_state == START);
      r_timeout_err <= w_timeout;
      if (w_grant) begin
        r_data     <= req_data[w_gnt_idx*DATA_W +: DATA_W];
        r_grant_id <= w_gnt_idx;
        r_req_ack  <= w_gnt_oh;
      end
      // Abort advances the pointer exactly like a completed byte.
      if (w_finish) begin
        if (r_grant_id == IDX_W'(NUM_REQ - 1)) begin
          r_rr_ptr <= '0;
        end else begin
          r_rr_ptr <= r_grant_id + 1'b1;
        end
      end
    end
  end

  assign req_ack     = r_req_ack;
  assign tx_start    = r_tx_start;
  assign data_in     = r_data;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: self-checking bench for uart_tx_scheduler (directed steps plus randomized transfers).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 50;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic            tx_start;
  logic [DW-1:0]   data_in;
  logic            tx_done;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_done = 0;
  int m_ptr    = 0;   // reference round-robin pointer

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_start    (tx_start),
    .data_in     (data_in),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = first valid requester scanning upward from ptr, modulo N.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Entered in an IDLE cycle. dly = cycles from tx_start to tx_done (<0: leave in WAIT).
  // done_early drives tx_done during the IDLE and START cycles, which must be ignored.
  task automatic do_xfer(input string tag, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input int dly, input bit b2b, input bit done_early);
    int            w;
    logic [DW-1:0] exp_b;
    logic [N-1:0]  oh;
    w     = pick(v, m_ptr);
    exp_b = d[w*DW +: DW];
    oh    = '0;
    oh[w] = 1'b1;
    req_valid = v;
    req_data  = d;
    tx_done   = done_early;
    check({tag, ".ack_not_yet"}, 32'(req_ack), 32'h0);
    tick();  // START
    check({tag, ".ack"}, 32'(req_ack), 32'(oh));
    check({tag, ".grant_id"}, 32'(grant_id), w);
    check({tag, ".start_busy"}, {30'h0, busy, tx_start}, 32'h2);
    // Changing requests after the ack must not disturb the transfer.
    req_valid = N'($urandom);
    req_data  = $urandom;
    tick();  // first WAIT cycle, tx_start pulse
    tx_done = 1'b0;
    check({tag, ".tx_start"}, {22'h0, tx_start, busy, req_ack, exp_b ^ data_in}, {22'h0, 1'b1, 1'b1, 4'h0, 8'h0});
    check({tag, ".data_in"}, 32'(data_in), 32'(exp_b));
    if (b2b) check({tag, ".b2b_gap"}, cyc - last_done, 3);
    if (dly < 0) return;
    for (int i = 0; i < dly; i++) begin
      tick();
      req_valid = N'($urandom);
      check({tag, ".hold"}, {18'h0, tx_start, busy, timeout_err, data_in, grant_id},
            {18'h0, 1'b0, 1'b1, 1'b0, exp_b, 2'(w)});
    end
    tx_done   = 1'b1;
    req_valid = '0;
    last_done = cyc;
    tick();  // back in IDLE
    tx_done = 1'b0;
    check({tag, ".release"}, {30'h0, busy, timeout_err}, 32'h0);
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    logic [N-1:0] v;
    int           s;
    int           hit;
    bit           prev;

    // 1. reset with all requesters valid
    rst       = 1'b1;
    req_valid = '1;
    req_data  = 32'h44332211;
    tx_done   = 1'b0;
    #3 rst = 1'b0;
    tick();
    tick();
    check("rst.req_ack", 32'(req_ack), 32'h0);
    check("rst.ctrl", {28'h0, tx_start, busy, timeout_err, 1'b0}, 32'h0);
    check("rst.data_in", 32'(data_in), 32'h0);
    check("rst.grant_id", 32'(grant_id), 32'h0);
    rst = 1'b1;
    m_ptr = 0;
    do_xfer("t1", 4'hF, 32'h44332211, 2, 0, 0);

    // 2. single requester 2, byte A5
    do_xfer("t2", 4'b0100, 32'h00A50000, 6, 0, 0);

    // 3. all valid, 12-cycle UART, back-to-back: order continues round robin
    for (int i = 0; i < 5; i++) begin
      do_xfer("t3", 4'hF, 32'h13121110, 12, i > 0, 0);
    end

    // 4. tx_done in IDLE (no request) and in IDLE/START of a transfer is ignored
    req_valid = '0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t4.idle_done", {29'h0, busy, tx_start, timeout_err}, 32'h0);
    do_xfer("t4", 4'b1010, 32'h5A00C300, 3, 0, 1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // 5. watchdog abort, then tx_done exactly on the expiry cycle
    do_xfer("t5", 4'b0100, 32'h00770000, -1, 0, 0);
    s   = cyc;
    hit = -1;
    for (int i = 0; i < 100 && hit < 0; i++) begin
      tick();
      if (timeout_err === 1'b1) hit = cyc;
    end
    check("t5.timeout_at", hit - s, TO);
    check("t5.busy_after", 32'(busy), 32'h0);
    m_ptr = (2 + 1) % N;
    req_valid = '0;
    tick();
    check("t5.pulse_width", 32'(timeout_err), 32'h0);
    do_xfer("t5.next", 4'hF, 32'hDDCCBBAA, 1, 0, 0);
    do_xfer("t5.race", 4'b0010, 32'h00006600, TO - 1, 0, 0);
`else
    // 5. without the watchdog WAIT holds indefinitely
    do_xfer("t5", 4'b0100, 32'h00770000, -1, 0, 0);
    hit = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      tick();
      if (timeout_err !== 1'b0 || busy !== 1'b1) hit++;
    end
    check("t5.no_abort", hit, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t5.done", 32'(busy), 32'h0);
    m_ptr = (2 + 1) % N;
`endif

    // 6. reset during WAIT; pointer made non-zero first
    req_valid = '0;
    tick();
    do_xfer("t6.pre", 4'b0001, 32'h000000EE, 1, 0, 0);
    do_xfer("t6", 4'hF, 32'h0F0E0D0C, -1, 0, 0);
    tick();
    req_valid = '1;
    #2 rst = 1'b0;
    #1;
    check("t6.async_ack", 32'(req_ack), 32'h0);
    check("t6.async_ctrl", {29'h0, tx_start, busy, timeout_err}, 32'h0);
    check("t6.async_data", {22'h0, data_in, grant_id}, 32'h0);
    m_ptr = 0;
    tick();
    tick();
    check("t6.in_reset", {30'h0, tx_start, busy}, 32'h0);
    rst = 1'b1;
    do_xfer("t6.restart", 4'hF, 32'h0F0E0D0C, 2, 0, 0);

    // Randomized transfers against the reference pointer model.
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v = N'($urandom_range(0, 15));
      if (v == '0) begin
        req_valid = '0;
        tick();
        check("rnd.idle", {30'h0, busy, |req_ack}, 32'h0);
        prev = 1'b0;
      end else begin
        do_xfer("rnd", v, $urandom, $urandom_range(0, 8), prev, 0);
        prev = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
